// File: rtl/div_scheduler.sv
// div_scheduler: requester side of the bike-computer divider interface.
// Latches speed / average-speed division requests, arbitrates between them,
// drives one operation at a time into the shared divider and collects the
// quotient into per-channel result registers (with divide-by-zero and
// timeout handling).
module div_scheduler #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spd_req,
  input  logic [WIDTH-1:0] spd_num,
  input  logic [WIDTH-1:0] spd_den,
  input  logic             avg_req,
  input  logic [WIDTH-1:0] avg_num,
  input  logic [WIDTH-1:0] avg_den,
  output logic [WIDTH-1:0] Dividend_spd,
  output logic [WIDTH-1:0] Divisor_spd,
  output logic [WIDTH-1:0] Dividend_avg_spd,
  output logic [WIDTH-1:0] Divisor_avg_spd,
  output logic             In_sel,
  output logic             Start,
  input  logic [WIDTH-1:0] Res,
  input  logic             Valid_out,
  output logic [WIDTH-1:0] spd_out,
  output logic             spd_upd,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_upd,
  output logic             timeout_err
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    CH_SPD = 1'b0,
    CH_AVG = 1'b1
  } chan_t;

  state_t           r_state;
  chan_t            r_last_sel;
  logic [CW-1:0]    r_cnt;

  logic             r_spd_pend;
  logic             r_avg_pend;
  logic [WIDTH-1:0] r_spd_num;
  logic [WIDTH-1:0] r_spd_den;
  logic [WIDTH-1:0] r_avg_num;
  logic [WIDTH-1:0] r_avg_den;

  logic             w_grant;
  chan_t            w_grant_sel;
  logic [WIDTH-1:0] w_grant_num;
  logic [WIDTH-1:0] w_grant_den;
  logic             w_grant_zero;
  logic             w_take_spd;
  logic             w_take_avg;

  // Arbitration: single pending channel wins outright, contention alternates.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_sel = CH_SPD;
    if (r_state == S_IDLE && (r_spd_pend || r_avg_pend)) begin
      w_grant = 1'b1;
      if (r_spd_pend && r_avg_pend) begin
        w_grant_sel = (r_last_sel == CH_AVG) ? CH_SPD : CH_AVG;
      end else if (r_avg_pend) begin
        w_grant_sel = CH_AVG;
      end else begin
        w_grant_sel = CH_SPD;
      end
    end
    w_grant_num  = (w_grant_sel == CH_AVG) ? r_avg_num : r_spd_num;
    w_grant_den  = (w_grant_sel == CH_AVG) ? r_avg_den : r_spd_den;
    w_grant_zero = (w_grant_den == '0);
    w_take_spd   = w_grant && (w_grant_sel == CH_SPD);
    w_take_avg   = w_grant && (w_grant_sel == CH_AVG);
  end

  // Shadow operand capture: the latest request on a channel overwrites.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_spd_num <= '0;
      r_spd_den <= '0;
      r_avg_num <= '0;
      r_avg_den <= '0;
    end else begin
      if (spd_req) begin
        r_spd_num <= spd_num;
        r_spd_den <= spd_den;
      end
      if (avg_req) begin
        r_avg_num <= avg_num;
        r_avg_den <= avg_den;
      end
    end
  end

  // Pending flags: a fresh request re-arms even on the edge that grants it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_spd_pend <= 1'b0;
      r_avg_pend <= 1'b0;
    end else begin
      r_spd_pend <= spd_req | (r_spd_pend & ~w_take_spd);
      r_avg_pend <= avg_req | (r_avg_pend & ~w_take_avg);
    end
  end

  // Scheduler FSM with registered divider-side and result-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_last_sel       <= CH_AVG;
      r_cnt            <= '0;
      Dividend_spd     <= '0;
      Divisor_spd      <= '0;
      Dividend_avg_spd <= '0;
      Divisor_avg_spd  <= '0;
      In_sel           <= 1'b0;
      Start            <= 1'b0;
      spd_out          <= '0;
      spd_upd          <= 1'b0;
      avg_out          <= '0;
      avg_upd          <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      Start       <= 1'b0;
      spd_upd     <= 1'b0;
      avg_upd     <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last_sel <= w_grant_sel;
            if (w_grant_zero) begin
              // Quotient by zero is reported as 0 without touching the divider.
              if (w_grant_sel == CH_AVG) begin
                avg_out <= '0;
                avg_upd <= 1'b1;
              end else begin
                spd_out <= '0;
                spd_upd <= 1'b1;
              end
            end else begin
              if (w_grant_sel == CH_AVG) begin
                Dividend_avg_spd <= w_grant_num;
                Divisor_avg_spd  <= w_grant_den;
              end else begin
                Dividend_spd <= w_grant_num;
                Divisor_spd  <= w_grant_den;
              end
              In_sel  <= w_grant_sel;
              Start   <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A result on the expiry edge takes priority over the timeout.
          if (Valid_out) begin
            if (In_sel == CH_AVG) begin
              avg_out <= Res;
              avg_upd <= 1'b1;
            end else begin
              spd_out <= Res;
              spd_upd <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
